// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: MDOp encodings,
// FSM state type and datapath width. Also imported by the hazard unit.
package mult_div_ctrl_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // True for the ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_ctrl_md_arith.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for
// MULT/MULTU/DIV/DIVU and flags a zero divisor so the sequencer can leave
// HI/LO untouched in that case.
module mult_div_ctrl_md_arith
    import mult_div_ctrl_pkg::*;
(
    input  md_op_t              op,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    output logic [DATA_W-1:0]   hi,
    output logic [DATA_W-1:0]   lo,
    output logic                div0
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;
    logic signed [DATA_W-1:0]   a_s;
    logic signed [DATA_W-1:0]   b_s;
    logic                       b_zero;
    logic                       div_ovf;

    assign a_s     = $signed(a);
    assign b_s     = $signed(b);
    assign b_zero  = (b == '0);
    // Most-negative / -1 overflows the quotient; the result wraps to the dividend.
    assign div_ovf = (a == {1'b1, {(DATA_W-1){1'b0}}}) && (b == {DATA_W{1'b1}});
    assign prod_s  = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign prod_u  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

    // Select the result pair for the requested op; divides are guarded against a zero divisor.
    always_comb begin
        hi   = '0;
        lo   = '0;
        div0 = 1'b0;
        case (op)
            MD_MULT: begin
                hi = prod_s[2*DATA_W-1:DATA_W];
                lo = prod_s[DATA_W-1:0];
            end
            MD_MULTU: begin
                hi = prod_u[2*DATA_W-1:DATA_W];
                lo = prod_u[DATA_W-1:0];
            end
            MD_DIV: begin
                if (b_zero) begin
                    div0 = 1'b1;
                end else if (div_ovf) begin
                    lo = a;
                    hi = '0;
                end else begin
                    lo = $unsigned(a_s / b_s);
                    hi = $unsigned(a_s % b_s);
                end
            end
            MD_DIVU: begin
                if (b_zero) begin
                    div0 = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
            default: begin
                hi   = '0;
                lo   = '0;
                div0 = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Multi-cycle multiply/divide sequencer for the E stage. Owns HI/LO,
// computes the result at accept time, holds it in pending registers and
// commits it after MULT_CYCLES / DIV_CYCLES of Busy.
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start_E,
    input  logic [2:0]        MDOp_E,
    input  logic [DATA_W-1:0] SrcA_E,
    input  logic [DATA_W-1:0] SrcB_E,
    output logic              Busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_op_t            op_in;
    md_state_t         state;
    md_state_t         state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              finish;
    logic              write_hi;
    logic              write_lo;

    logic [DATA_W-1:0] arith_hi;
    logic [DATA_W-1:0] arith_lo;
    logic              arith_div0;
    logic [DATA_W-1:0] pend_hi;
    logic [DATA_W-1:0] pend_lo;
    logic              pend_div0;

    assign op_in = md_op_t'(MDOp_E);

    mult_div_ctrl_md_arith u_arith (
        .op   (op_in),
        .a    (SrcA_E),
        .b    (SrcB_E),
        .hi   (arith_hi),
        .lo   (arith_lo),
        .div0 (arith_div0)
    );

    // Next-state, counter and commit decisions; Start_E only acts in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        finish     = 1'b0;
        write_hi   = 1'b0;
        write_lo   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start_E) begin
                    if (is_long_op(op_in)) begin
                        accept     = 1'b1;
                        state_next = ST_RUN;
                        if ((op_in == MD_MULT) || (op_in == MD_MULTU)) begin
                            cnt_next = CNT_W'(MULT_CYCLES);
                        end else begin
                            cnt_next = CNT_W'(DIV_CYCLES);
                        end
                    end else if (op_in == MD_MTHI) begin
                        write_hi = 1'b1;
                    end else if (op_in == MD_MTLO) begin
                        write_lo = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers; reset overrides all.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            Busy      <= 1'b0;
            HI        <= '0;
            LO        <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_div0 <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            Busy  <= (state_next == ST_RUN);
            if (accept) begin
                pend_hi   <= arith_hi;
                pend_lo   <= arith_lo;
                pend_div0 <= arith_div0;
            end
            if (finish && !pend_div0) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
            if (write_hi) begin
                HI <= SrcA_E;
            end
            if (write_lo) begin
                LO <= SrcA_E;
            end
        end
    end

endmodule
